// File: rtl/memory_bank_io.sv
// memory_bank_io: small word-addressed memory with a memory-mapped input register (synchronised
// button levels plus sticky rising-edge flags) and an output register (LEDs), all threaded onto
// a single serial scan chain.
//
// Ports:
//   clk           - clock, all state updates on the rising edge
//   rst           - synchronous active-low reset, wins over scan and writes
//   address       - word address: RAM, then IN_ADDR, then OUT_ADDR, rest unmapped
//   data_in       - write data
//   write_enable  - functional write strobe (ignored while scan_enable=1)
//   data_out      - combinational read data (zero for unmapped addresses)
//   scan_enable   - scan shift mode
//   scan_in       - serial chain input (enters RAM[0] MSB)
//   scan_out      - serial chain output (output register bit 0)
//   in_pins       - asynchronous external inputs
//   out_port      - output register
//   irq           - OR of all edge flags
module memory_bank_io #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 28,
  parameter int unsigned IN_WIDTH   = 4,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  scan_enable,
  input  logic                  scan_in,
  output logic                  scan_out,
  input  logic [IN_WIDTH-1:0]   in_pins,
  output logic [OUT_WIDTH-1:0]  out_port,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] IN_ADDR  = ADDR_WIDTH'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] OUT_ADDR = ADDR_WIDTH'(MEM_SIZE + 1);

  logic [DATA_WIDTH-1:0] ram_q [MEM_SIZE];
  logic [IN_WIDTH-1:0]   sync1_q, level_q, prev_q;
  logic [IN_WIDTH-1:0]   flag_q, flag_d;
  logic [OUT_WIDTH-1:0]  out_q, out_d;

  logic                  func_we;
  logic                  ram_we;
  logic [IN_WIDTH-1:0]   rise;
  logic [IN_WIDTH-1:0]   clr;

  assign func_we = write_enable & ~scan_enable;
  assign ram_we  = func_we && (address < IN_ADDR);
  assign rise    = level_q & ~prev_q;
  assign clr     = (func_we && (address == IN_ADDR)) ? data_in[IN_WIDTH +: IN_WIDTH] : '0;

  // Synchroniser and edge-detect history keep running in scan mode, so a rising edge seen
  // while scanning is consumed by prev and never reaches a flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in_pins;
      level_q <= sync1_q;
      prev_q  <= level_q;
    end
  end

  // RAM: scan shifts MSB-in, bit 0 of each word feeds the MSB of the next word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_SIZE; i++) ram_q[i] <= '0;
    end else if (scan_enable) begin
      ram_q[0] <= {scan_in, ram_q[0][DATA_WIDTH-1:1]};
      for (int i = 1; i < MEM_SIZE; i++) begin
        ram_q[i] <= {ram_q[i-1][0], ram_q[i][DATA_WIDTH-1:1]};
      end
    end else if (ram_we) begin
      ram_q[address] <= data_in;
    end
  end

  always_comb begin
    flag_d = flag_q;
    out_d  = out_q;
    if (scan_enable) begin
      flag_d = IN_WIDTH'({ram_q[MEM_SIZE-1][0], flag_q} >> 1);
      out_d  = OUT_WIDTH'({flag_q[0], out_q} >> 1);
    end else begin
      // Set is applied after clear so a coincident edge keeps the flag.
      flag_d = (flag_q & ~clr) | rise;
      if (func_we && (address == OUT_ADDR)) begin
        out_d = data_in[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_q <= '0;
      out_q  <= '0;
    end else begin
      flag_q <= flag_d;
      out_q  <= out_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (address < IN_ADDR) begin
      data_out = ram_q[address];
    end else if (address == IN_ADDR) begin
      data_out = DATA_WIDTH'({flag_q, level_q});
    end else if (address == OUT_ADDR) begin
      data_out = DATA_WIDTH'(out_q);
    end
  end

  assign out_port = out_q;
  assign irq      = |flag_q;
  assign scan_out = out_q[0];

endmodule

// File: doc/memory_bank_io.md
MEMORY_BANK_IO -- requirements
Module: memory_bank_io

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 5, meaning the address bus width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, meaning the word width.
REQ-003 The module SHALL have parameter MEM_SIZE, default 28, meaning the number of RAM words; MEM_SIZE+2 <= 2**ADDR_WIDTH.
REQ-004 The module SHALL have parameter IN_WIDTH, default 4, meaning the number of input pins; 2*IN_WIDTH <= DATA_WIDTH.
REQ-005 The module SHALL have parameter OUT_WIDTH, default 8, meaning the output port width; OUT_WIDTH <= DATA_WIDTH.
REQ-006 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst  input  1  is the reset: synchronous, active-low.
REQ-008 Port address  input  ADDR_WIDTH  is the word address.
REQ-009 Port data_in  input  DATA_WIDTH  is the write data.
REQ-010 Port write_enable  input  1  is the functional write strobe.
REQ-011 Port data_out  output  DATA_WIDTH  is the combinational read data.
REQ-012 Port scan_enable  input  1  selects scan shift mode.
REQ-013 Port scan_in  input  1  is the serial scan input.
REQ-014 Port scan_out  output  1  is the serial scan output.
REQ-015 Port in_pins  input  IN_WIDTH  carries asynchronous external inputs (buttons).
REQ-016 Port out_port  output  OUT_WIDTH  drives external outputs (LEDs).
REQ-017 Port irq  output  1  is high while any edge flag is set.

Function
REQ-018 Address map SHALL be: 0..MEM_SIZE-1 RAM; IN_ADDR=MEM_SIZE input register; OUT_ADDR=MEM_SIZE+1 output register; all higher addresses unmapped.
REQ-019 A RAM write SHALL occur when write_enable=1, scan_enable=0 and address<MEM_SIZE; the word is visible on data_out the next cycle.
REQ-020 A RAM read SHALL return the word at address combinationally (zero read latency).
REQ-021 Each in_pins bit SHALL pass through a 2-flop synchronizer; the second-stage value is "level" and a third flop holds "prev".
REQ-022 A rising edge (level=1, prev=0) SHALL set the matching edge flag on the next clock; flags are sticky.
REQ-023 A write to IN_ADDR SHALL clear each flag i for which data_in[IN_WIDTH+i]=1; other flags are unchanged.
REQ-024 Simultaneous set and clear of the same flag SHALL leave the flag set (set wins).
REQ-025 A read of IN_ADDR SHALL return {zeros, flags[IN_WIDTH-1:0], level[IN_WIDTH-1:0]}, levels in the LSBs.
REQ-026 A write to OUT_ADDR SHALL load data_in[OUT_WIDTH-1:0] into the output register; a read returns it zero-extended.
REQ-027 out_port SHALL equal the output register; irq SHALL be the OR of all flags (combinational from flops).
REQ-028 Reads of unmapped addresses SHALL return 0, and writes to them SHALL be ignored.
REQ-029 Pin-to-level latency SHALL be 2 cycles; pin-to-flag latency SHALL be 3 cycles.
REQ-030 With scan_enable=1, functional writes, flag set and flag clear SHALL be suppressed; synchronizer and prev flops keep running.
REQ-031 In scan mode, each clock SHALL shift the chain one bit: scan_in -> RAM[0] ... RAM[MEM_SIZE-1] -> flags -> output register -> scan_out.
REQ-032 Within each element, the incoming bit SHALL enter the MSB, bits SHALL shift toward the LSB, and bit 0 SHALL feed the next element.
REQ-033 Chain length SHALL be MEM_SIZE*DATA_WIDTH+IN_WIDTH+OUT_WIDTH; scan_out SHALL be bit 0 of the output register (registered).
REQ-034 A rising edge detected during scan mode SHALL be lost (not deferred).

Reset
REQ-035 When rst=0 at a clock edge, all RAM words, flags, output register, synchronizer and prev flops SHALL be cleared to 0; rst has priority over scan and writes.
REQ-036 After reset, out_port=0, irq=0, scan_out=0, and data_out=0 for every address.
REQ-037 Reset asserted mid-scan SHALL abort the shift, and shifting SHALL resume from an all-zero chain.

Verification
REQ-038 Write 0xA5 to addr 3, then read addr 3 -> 0xA5; read addr 30 -> 0x00.
REQ-039 Raise in_pins[1] at cycle 0 -> IN_ADDR reads 0x02 at cycle 2 and 0x22 at cycle 3, irq=1; write 0x20 to IN_ADDR -> reads 0x02, irq=0.
REQ-040 Hold in_pins[0] rising edge coincident with a clear write of 0x10 -> flag0 remains 1.
REQ-041 Write 0x3C to OUT_ADDR -> out_port=0x3C next cycle; read OUT_ADDR -> 0x3C.
REQ-042 Scan in 236 bits with pattern 0x5A at RAM[0] position -> RAM[0] reads 0x5A; shift 236 more -> scan_out replays the original bitstream in order.
REQ-043 Pulse rst=0 during scan and write 0xFF -> every address reads 0x00, and out_port=0.
